// File: rtl/lsu_mem_stage.sv
// Load/store unit for the MEM stage. It accepts one request at a time and
// checks RV32 alignment. It drives the data-memory controller through its
// busy/idle ready handshake, and returns a single-cycle response to writeback.
//
// state      | meaning
// IDLE       | ready for a new request
// ISSUE      | waiting for the controller to be idle, then pulsing the enable
// WAIT_LOW   | waiting for the controller to go busy
// WAIT_HIGH  | waiting for the controller to become idle again
// DONE       | presenting the response for one cycle
module lsu_mem_stage #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_is_load,
    input  logic                     req_is_store,
    input  logic [2:0]               req_func3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    input  logic [4:0]               req_rd,
    input  logic                     flush,
    output logic                     resp_valid,
    output logic [4:0]               resp_rd,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_misaligned,
    output logic                     resp_timeout,
    output logic                     mem_read_En,
    output logic                     mem_write_En,
    output logic [2:0]               mem_func3,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_data_in,
    input  logic [DATA_WIDTH-1:0]    mem_data_out,
    input  logic                     mem_ready,
    output logic                     busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_LOW  = 3'd2;
    localparam logic [2:0] S_WAIT_HIGH = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    localparam int          CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [2:0]            state, state_nxt;
    logic [CW-1:0]         tmo_cnt, cnt_nxt;
    logic                  kill;
    logic                  op_load, op_store;
    logic [4:0]            rd_q;
    logic                  req_load, req_store, misaligned, tmo_hit;
    logic                  accept, go_done, mis_nxt, tmo_nxt, rd_en_nxt, wr_en_nxt;
    logic [DATA_WIDTH-1:0] rdata_nxt;

    // Load takes priority when both type bits are set; halfword and word alignment only
    always_comb begin
        req_load   = req_is_load;
        req_store  = req_is_store & ~req_is_load;
        misaligned = (((req_func3 == 3'b001) || (req_func3 == 3'b101)) && req_addr[0]) ||
                     ((req_func3 == 3'b010) && (req_addr[1:0] != 2'b00));
        tmo_hit    = (tmo_cnt == TMO_LAST);
    end

    // Next-state, enable and response selection
    always_comb begin
        state_nxt = state;
        cnt_nxt   = tmo_cnt + CW'(1);
        accept    = 1'b0;
        go_done   = 1'b0;
        mis_nxt   = 1'b0;
        tmo_nxt   = 1'b0;
        rd_en_nxt = 1'b0;
        wr_en_nxt = 1'b0;
        rdata_nxt = '0;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (req_valid && !flush) begin
                    accept = 1'b1;
                    if (!req_load && !req_store) begin
                        go_done = 1'b1;
                    end else if (misaligned) begin
                        go_done = 1'b1;
                        mis_nxt = 1'b1;
                    end else begin
                        state_nxt = S_ISSUE;
                        rd_en_nxt = req_load & mem_ready;
                        wr_en_nxt = req_store & mem_ready;
                    end
                end
            end
            S_ISSUE: begin
                if (mem_read_En || mem_write_En) begin
                    state_nxt = S_WAIT_LOW;
                    cnt_nxt   = '0;
                end else if (tmo_hit) begin
                    go_done = 1'b1;
                    tmo_nxt = 1'b1;
                end else begin
                    rd_en_nxt = op_load & mem_ready;
                    wr_en_nxt = op_store & mem_ready;
                end
            end
            S_WAIT_LOW: begin
                if (!mem_ready) begin
                    state_nxt = S_WAIT_HIGH;
                    cnt_nxt   = '0;
                end else if (tmo_hit) begin
                    go_done = 1'b1;
                    tmo_nxt = 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                if (mem_ready) begin
                    go_done   = 1'b1;
                    rdata_nxt = op_load ? mem_data_out : '0;
                end else if (tmo_hit) begin
                    go_done = 1'b1;
                    tmo_nxt = 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
        if (go_done) state_nxt = S_DONE;
    end

    // State, latched request and registered outputs
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state           <= S_IDLE;
            tmo_cnt         <= '0;
            kill            <= 1'b0;
            op_load         <= 1'b0;
            op_store        <= 1'b0;
            rd_q            <= '0;
            req_ready       <= 1'b1;
            busy            <= 1'b0;
            resp_valid      <= 1'b0;
            resp_rd         <= '0;
            resp_rdata      <= '0;
            resp_misaligned <= 1'b0;
            resp_timeout    <= 1'b0;
            mem_read_En     <= 1'b0;
            mem_write_En    <= 1'b0;
            mem_func3       <= '0;
            mem_address     <= '0;
            mem_data_in     <= '0;
        end else begin
            state        <= state_nxt;
            tmo_cnt      <= cnt_nxt;
            req_ready    <= (state_nxt == S_IDLE);
            busy         <= (state_nxt != S_IDLE);
            mem_read_En  <= rd_en_nxt;
            mem_write_En <= wr_en_nxt;
            // A flushed transaction still completes on the bus; only its response is dropped
            if (state == S_DONE) kill <= 1'b0;
            else if (flush && (state != S_IDLE)) kill <= 1'b1;
            if (accept) begin
                op_load     <= req_load;
                op_store    <= req_store;
                rd_q        <= req_rd;
                mem_func3   <= req_func3;
                mem_address <= req_addr;
                mem_data_in <= req_wdata;
            end
            resp_valid      <= go_done & ~kill & ~flush;
            resp_rd         <= go_done ? ((state == S_IDLE) ? req_rd : rd_q) : 5'd0;
            resp_rdata      <= rdata_nxt;
            resp_misaligned <= mis_nxt;
            resp_timeout    <= tmo_nxt;
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with a small behavioural memory controller
// (load busy four cycles, store busy one cycle).
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rstN = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_load = 1'b0;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_func3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic [4:0]  resp_rd;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_timeout;
    logic        mem_read_En;
    logic        mem_write_En;
    logic [2:0]  mem_func3;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out = '0;
    logic        mem_ready = 1'b1;
    logic        busy;

    int total = 0;
    int bad = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int resp_cnt = 0;
    int busy_cnt = 0;
    logic hold_low = 1'b0;
    logic [31:0] mem_arr [0:15];
    int cyc;
    int pre;

    lsu_mem_stage #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rstN(rstN),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_is_load(req_is_load),
        .req_is_store(req_is_store),
        .req_func3(req_func3),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_rd(req_rd),
        .flush(flush),
        .resp_valid(resp_valid),
        .resp_rd(resp_rd),
        .resp_rdata(resp_rdata),
        .resp_misaligned(resp_misaligned),
        .resp_timeout(resp_timeout),
        .mem_read_En(mem_read_En),
        .mem_write_En(mem_write_En),
        .mem_func3(mem_func3),
        .mem_address(mem_address),
        .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out),
        .mem_ready(mem_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Controller model: enable sampled while idle, ready low for the busy window
    always @(posedge clk) begin
        if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) mem_ready <= !hold_low;
        end else if (mem_read_En && mem_ready) begin
            busy_cnt     <= 4;
            mem_ready    <= 1'b0;
            mem_data_out <= mem_arr[mem_address[5:2]];
        end else if (mem_write_En && mem_ready) begin
            busy_cnt  <= 1;
            mem_ready <= 1'b0;
            mem_arr[mem_address[5:2]] <= mem_data_in;
        end else begin
            mem_ready <= !hold_low;
        end
    end

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (mem_read_En) rd_cnt++;
        if (mem_write_En) wr_cnt++;
        if (resp_valid) resp_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
        req_valid    = 1'b1;
        req_is_load  = ld;
        req_is_store = st;
        req_func3    = f3;
        req_addr     = addr;
        req_wdata    = wdata;
        req_rd       = rd;
        step();
        req_valid    = 1'b0;
        req_is_load  = 1'b0;
        req_is_store = 1'b0;
    endtask

    // Cycles from the accept cycle to resp_valid; -1 when the bound expires
    task automatic wait_resp(output int n);
        n = 1;
        while (!resp_valid && n < 40) begin
            step();
            n++;
        end
        if (!resp_valid) n = -1;
    endtask

    initial begin
        #2 rstN = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_rd_en", mem_read_En, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rstN = 1'b1;
        step();
        step();

        // Word store to 0x10
        issue(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0);
        check("sw_wr_en", mem_write_En, 1);
        check("sw_req_ready_low", req_ready, 0);
        check("sw_busy", busy, 1);
        check("sw_addr", mem_address, 32'h10);
        wait_resp(cyc);
        check("sw_latency", cyc, 4);
        check("sw_flags", {resp_misaligned, resp_timeout}, 0);
        check("sw_rdata", resp_rdata, 0);
        step();
        check("sw_back_idle", req_ready, 1);

        // Word load from 0x10, accepted right after DONE
        issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd5);
        check("lw_rd_en", mem_read_En, 1);
        check("lw_wr_en", mem_write_En, 0);
        wait_resp(cyc);
        check("lw_latency", cyc, 7);
        check("lw_rdata", resp_rdata, 32'hDEADBEEF);
        check("lw_rd", resp_rd, 5);
        check("lw_flags", {resp_misaligned, resp_timeout}, 0);
        step();
        check("lw_valid_pulse", resp_valid, 0);

        // Store then load at 0x20
        issue(1'b0, 1'b1, 3'b010, 32'h20, 32'h12345678, 5'd0);
        wait_resp(cyc);
        check("sw2_latency", cyc, 4);
        step();
        issue(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 5'd7);
        wait_resp(cyc);
        check("lw2_latency", cyc, 7);
        check("lw2_rdata", resp_rdata, 32'h12345678);
        check("lw2_rd", resp_rd, 7);
        step();
        check("en_counts", {rd_cnt[15:0], wr_cnt[15:0]}, {16'd2, 16'd2});

        // Misaligned halfword load and word store
        issue(1'b1, 1'b0, 3'b001, 32'h21, 32'h0, 5'd3);
        wait_resp(cyc);
        check("lh_mis_latency", cyc, 1);
        check("lh_mis_flag", resp_misaligned, 1);
        check("lh_mis_rdata", resp_rdata, 0);
        check("lh_mis_rd", resp_rd, 3);
        step();
        issue(1'b0, 1'b1, 3'b010, 32'h22, 32'hFFFF0000, 5'd0);
        wait_resp(cyc);
        check("sw_mis_latency", cyc, 1);
        check("sw_mis_flag", resp_misaligned, 1);
        step();
        check("mis_no_access", {rd_cnt[15:0], wr_cnt[15:0]}, {16'd2, 16'd2});

        // Neither load nor store
        issue(1'b0, 1'b0, 3'b010, 32'h23, 32'h0, 5'd9);
        wait_resp(cyc);
        check("noop_latency", cyc, 1);
        check("noop_flags", {resp_misaligned, resp_timeout}, 0);
        check("noop_rd", resp_rd, 9);
        step();

        // Byte load at an odd address is never misaligned
        issue(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 5'd4);
        wait_resp(cyc);
        check("lb_latency", cyc, 7);
        check("lb_mis", resp_misaligned, 0);
        check("lb_rdata", resp_rdata, 32'hDEADBEEF);
        step();

        // Flush in IDLE blocks acceptance
        pre = resp_cnt;
        req_valid = 1'b1; req_is_load = 1'b1; req_func3 = 3'b010; req_addr = 32'h10;
        flush = 1'b1;
        step();
        req_valid = 1'b0; req_is_load = 1'b0; flush = 1'b0;
        check("idle_flush_busy", busy, 0);
        check("idle_flush_ready", req_ready, 1);
        step();
        step();
        check("idle_flush_no_resp", resp_cnt, pre);

        // Controller never ready: timeout after eight ISSUE cycles
        hold_low = 1'b1;
        step();
        step();
        issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd6);
        check("tmo_no_en", mem_read_En, 0);
        wait_resp(cyc);
        check("tmo_latency", cyc, 9);
        check("tmo_flag", resp_timeout, 1);
        check("tmo_rdata", resp_rdata, 0);
        check("tmo_rd", resp_rd, 6);
        step();
        hold_low = 1'b0;
        step();
        step();
        check("tmo_no_read", rd_cnt, 3);

        // Flush during WAIT_HIGH: read completes, response dropped
        pre = resp_cnt;
        issue(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 5'd8);
        step();
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_still_busy", busy, 1);
        for (int i = 0; i < 6; i++) step();
        check("flush_no_resp", resp_cnt, pre);
        check("flush_ready", req_ready, 1);
        check("flush_read_done", rd_cnt, 4);
        check("flush_ctrl_idle", mem_ready, 1);

        // Asynchronous reset during WAIT_LOW of a store
        issue(1'b0, 1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 5'd2);
        step();
        check("rst2_busy_before", busy, 1);
        rstN = 1'b0;
        #1;
        check("rst2_req_ready", req_ready, 1);
        check("rst2_busy", busy, 0);
        check("rst2_wr_en", mem_write_En, 0);
        check("rst2_addr", mem_address, 0);
        check("rst2_data", mem_data_in, 0);
        check("rst2_resp", resp_valid, 0);
        #1 rstN = 1'b1;
        step();
        step();
        issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd11);
        wait_resp(cyc);
        check("post_rst_latency", cyc, 7);
        check("post_rst_rdata", resp_rdata, 32'hDEADBEEF);
        check("post_rst_rd", resp_rd, 11);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
